// File: rtl/pixel_uart_packer_if.sv
// Bus bundle for pixel_uart_packer: capture-side pixel strobe plus the byte
// valid/ready handshake towards the UART transmitter.
interface pixel_uart_packer_if #(
   parameter int PixelBitWidth = 16
);
   logic                     i_frame_start;
   logic [PixelBitWidth-1:0] i_data;
   logic                     i_valid;
   logic [7:0]               o_tx_data;
   logic                     o_tx_valid;
   logic                     i_tx_ready;

   modport master (
      output i_frame_start,
      output i_data,
      output i_valid,
      output i_tx_ready,
      input  o_tx_data,
      input  o_tx_valid
   );

   modport slave (
      input  i_frame_start,
      input  i_data,
      input  i_valid,
      input  i_tx_ready,
      output o_tx_data,
      output o_tx_valid
   );
endinterface

// File: rtl/pixel_uart_packer.sv
// Crops captured pixel words to the active window, buffers them in a FIFO and
// serialises them high byte first to a UART, with a marker pair ahead of each frame.
module pixel_uart_packer #(
   parameter int         PixelBitWidth     = 16,
   parameter int         FrameWidth        = 640,
   parameter int         FrameHeight       = 480,
   parameter int         ActiveFrameWidth  = 512,
   parameter int         ActiveFrameHeight = 384,
   parameter int         HOffset           = 64,
   parameter int         VOffset           = 48,
   parameter int         FifoDepth         = 16,
   parameter logic [7:0] MarkerHi          = 8'hA5,
   parameter logic [7:0] MarkerLo          = 8'h5A
) (
   input  logic                       CLK,
   input  logic                       RST,
   pixel_uart_packer_if.slave         bus,
   output logic                       o_overflow,
   output logic [$clog2(FifoDepth):0] o_level
);
   localparam int ColW   = $clog2(FrameWidth + 1);
   localparam int RowW   = $clog2(FrameHeight + 1);
   localparam int AddrW  = $clog2(FifoDepth);
   localparam int LvlW   = AddrW + 1;
   localparam int EntryW = PixelBitWidth + 1;

   localparam logic [ColW-1:0] ColFirst = ColW'(HOffset);
   localparam logic [ColW-1:0] ColEnd   = ColW'(HOffset + ActiveFrameWidth);
   localparam logic [ColW-1:0] ColLast  = ColW'(FrameWidth - 1);
   localparam logic [RowW-1:0] RowFirst = RowW'(VOffset);
   localparam logic [RowW-1:0] RowEnd   = RowW'(VOffset + ActiveFrameHeight);
   localparam logic [RowW-1:0] RowLast  = RowW'(FrameHeight - 1);
   localparam logic [LvlW-1:0] LvlFull  = LvlW'(FifoDepth);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] SEND_HI = 2'd1;
   localparam logic [1:0] SEND_LO = 2'd2;

   function automatic logic [7:0] hi_byte(input logic [EntryW-1:0] e);
      if (e[EntryW-1]) return MarkerHi;
      else             return e[PixelBitWidth-1 -: 8];
   endfunction

   function automatic logic [7:0] lo_byte(input logic [EntryW-1:0] e);
      if (e[EntryW-1]) return MarkerLo;
      else             return e[7:0];
   endfunction

   logic [ColW-1:0]   col_q, col_d;
   logic [RowW-1:0]   row_q, row_d;
   logic              done_q, done_d;
   logic [EntryW-1:0] mem_q [FifoDepth];
   logic [AddrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [LvlW-1:0]   level_q, level_d;
   logic              overflow_q, overflow_d;
   logic [1:0]        state_q, state_d;
   logic [EntryW-1:0] hold_q, hold_d;
   logic [7:0]        tx_data_q, tx_data_d;
   logic              tx_valid_q, tx_valid_d;

   logic              last_word_s, count_s, active_s, push_s, push_ok_s, pop_s;
   logic              full_s, empty_s, xfer_s;
   logic [EntryW-1:0] push_entry_s, head_s;

   assign full_s  = (level_q == LvlFull);
   assign empty_s = (level_q == LvlW'(0));
   assign head_s  = mem_q[rd_ptr_q];

   // Frame position tracking, cropping and FIFO entry selection.
   always_comb begin
      last_word_s = (col_q == ColLast) && (row_q == RowLast);
      count_s     = bus.i_valid && !bus.i_frame_start && !done_q;
      active_s    = (col_q >= ColFirst) && (col_q < ColEnd) &&
                    (row_q >= RowFirst) && (row_q < RowEnd);
      push_s      = bus.i_frame_start || (count_s && active_s);
      if (bus.i_frame_start) push_entry_s = {1'b1, {PixelBitWidth{1'b0}}};
      else                   push_entry_s = {1'b0, bus.i_data};

      col_d  = col_q;
      row_d  = row_q;
      done_d = done_q;
      if (bus.i_frame_start) begin
         col_d  = ColW'(0);
         row_d  = RowW'(0);
         done_d = 1'b0;
      end else if (count_s) begin
         if (last_word_s) begin
            done_d = 1'b1;
         end else if (col_q == ColLast) begin
            col_d = ColW'(0);
            row_d = row_q + RowW'(1);
         end else begin
            col_d = col_q + ColW'(1);
         end
      end else begin
         done_d = done_q;
      end
   end

   // FIFO bookkeeping; a pop in the same cycle frees room for a push when full.
   always_comb begin
      push_ok_s = push_s && (!full_s || pop_s);
      if (push_ok_s) wr_ptr_d = wr_ptr_q + AddrW'(1);
      else           wr_ptr_d = wr_ptr_q;
      if (pop_s) rd_ptr_d = rd_ptr_q + AddrW'(1);
      else       rd_ptr_d = rd_ptr_q;
      case ({push_ok_s, pop_s})
         2'b10:   level_d = level_q + LvlW'(1);
         2'b01:   level_d = level_q - LvlW'(1);
         default: level_d = level_q;
      endcase
      overflow_d = overflow_q || (push_s && !push_ok_s);
   end

   // Drain FSM; the output byte register is loaded directly from the popped
   // entry on back-to-back words so the link sees no idle cycle.
   always_comb begin
      state_d    = state_q;
      hold_d     = hold_q;
      tx_data_d  = tx_data_q;
      tx_valid_d = tx_valid_q;
      pop_s      = 1'b0;
      xfer_s     = tx_valid_q && bus.i_tx_ready;
      case (state_q)
         IDLE: begin
            if (!empty_s) begin
               pop_s   = 1'b1;
               hold_d  = head_s;
               state_d = SEND_HI;
            end else begin
               tx_valid_d = 1'b0;
            end
         end
         SEND_HI: begin
            if (!tx_valid_q) begin
               tx_valid_d = 1'b1;
               tx_data_d  = hi_byte(hold_q);
            end else if (xfer_s) begin
               tx_data_d = lo_byte(hold_q);
               state_d   = SEND_LO;
            end else begin
               state_d = SEND_HI;
            end
         end
         SEND_LO: begin
            if (xfer_s) begin
               if (!empty_s) begin
                  pop_s     = 1'b1;
                  hold_d    = head_s;
                  tx_data_d = hi_byte(head_s);
                  state_d   = SEND_HI;
               end else begin
                  tx_valid_d = 1'b0;
                  state_d    = IDLE;
               end
            end else begin
               state_d = SEND_LO;
            end
         end
         default: begin
            state_d    = IDLE;
            tx_valid_d = 1'b0;
         end
      endcase
   end

   // FIFO storage; contents are don't-care while the level says empty.
   always_ff @(posedge CLK) begin
      if (push_ok_s) mem_q[wr_ptr_q] <= push_entry_s;
   end

   // State registers.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         col_q      <= ColW'(0);
         row_q      <= RowW'(0);
         done_q     <= 1'b0;
         wr_ptr_q   <= AddrW'(0);
         rd_ptr_q   <= AddrW'(0);
         level_q    <= LvlW'(0);
         overflow_q <= 1'b0;
         state_q    <= IDLE;
         hold_q     <= EntryW'(0);
         tx_data_q  <= 8'h00;
         tx_valid_q <= 1'b0;
      end else begin
         col_q      <= col_d;
         row_q      <= row_d;
         done_q     <= done_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         overflow_q <= overflow_d;
         state_q    <= state_d;
         hold_q     <= hold_d;
         tx_data_q  <= tx_data_d;
         tx_valid_q <= tx_valid_d;
      end
   end

   assign bus.o_tx_data  = tx_data_q;
   assign bus.o_tx_valid = tx_valid_q;
   assign o_overflow     = overflow_q;
   assign o_level        = level_q;
endmodule
